card_slot_prefetcher: RTL and testbench

//  Sequences the per-frame fetch of the 10 card-slot indices (RAM[BASE_ADDR..BASE_ADDR+NUM_SLOTS-1]) once per

---
 rtl/card_slot_prefetcher.sv | 133 +++++++++++++
 tb/tb_card_slot_prefetcher.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_slot_prefetcher.sv
// Per-frame prefetch of the card-slot index table from the shared data-RAM read port.
// Fetched indices land in a shadow bank that is committed in one cycle, so display reads are frame-stable.
module card_slot_prefetcher #(
   parameter int unsigned NUM_SLOTS   = 10,
   parameter int unsigned BASE_ADDR   = 16,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned NUM_IMAGES  = 14,
   parameter int unsigned BLANK_IDX   = 0,
   parameter int unsigned STALL_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        cpu_gnt,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic [3:0]  slot_sel,
   output logic [31:0] slot_index,
   output logic        table_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] COMMIT = 2'd3;

   logic [1:0]    state;
   logic [IW-1:0] issue_ptr;
   logic [SW-1:0] stall_cnt;
   logic          pipe_vld [RD_LAT];
   logic [IW-1:0] pipe_tag [RD_LAT];
   logic [31:0]   shadow    [NUM_SLOTS];
   logic [31:0]   committed [NUM_SLOTS];

   logic pf_want;
   logic cpu_wins;
   logic pf_win;
   logic pending;

   assign pf_want  = (state == FETCH);
   assign cpu_wins = cpu_req && (32'(stall_cnt) < STALL_LIMIT);
   assign pf_win   = pf_want && !cpu_wins;
   assign cpu_gnt  = cpu_wins;
   assign mem_addr = pf_win ? (32'(BASE_ADDR) + 32'(issue_ptr)) : cpu_addr;
   assign busy     = (state != IDLE);

   // Returns still in flight behind the output stage; the output stage lands on the DRAIN->COMMIT edge.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < int'(RD_LAT) - 1; i++) pending = pending | pipe_vld[i];
   end

   always_comb begin
      slot_index = '0;
      if (32'(slot_sel) < NUM_SLOTS) slot_index = committed[slot_sel];
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         issue_ptr   <= '0;
         stall_cnt   <= '0;
         table_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         stall_cnt <= (pf_want && cpu_wins) ? stall_cnt + 1'b1 : '0;
         if (frame_start && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state     <= FETCH;
                  issue_ptr <= '0;
               end
            end
            FETCH: begin
               if (pf_win) begin
                  if (issue_ptr == IW'(NUM_SLOTS - 1)) state <= DRAIN;
                  else issue_ptr <= issue_ptr + 1'b1;
               end
            end
            DRAIN: begin
               if (!pending) state <= COMMIT;
            end
            COMMIT: begin
               state       <= IDLE;
               table_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_tag[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= pf_win;
         pipe_tag[0] <= issue_ptr;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   // NOTE: both banks are small register files that must read as zero after reset, so they are reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            shadow[i]    <= '0;
            committed[i] <= '0;
         end
      end else begin
         if (pipe_vld[RD_LAT-1])
            shadow[pipe_tag[RD_LAT-1]] <= (mem_rdata < NUM_IMAGES) ? mem_rdata : 32'(BLANK_IDX);
         if (state == COMMIT)
            for (int i = 0; i < int'(NUM_SLOTS); i++) committed[i] <= shadow[i];
      end
   end

endmodule

// File: tb/tb_card_slot_prefetcher.sv
// Self-checking bench for card_slot_prefetcher: RAM model, randomized processor traffic and a
// cycle-level arbitration/table model computed from the prefetch rules.
`timescale 1ns/1ps
module tb_card_slot_prefetcher;

   localparam int NUM_SLOTS   = 10;
   localparam int BASE_ADDR   = 16;
   localparam int RD_LAT      = 1;
   localparam int NUM_IMAGES  = 14;
   localparam int BLANK_IDX   = 0;
   localparam int STALL_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_start = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_gnt;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [3:0]  slot_sel = '0;
   logic [31:0] slot_index;
   logic        table_valid;
   logic        busy;
   logic        overrun;

   logic [31:0] ram [64];
   logic [31:0] model_tbl [NUM_SLOTS];
   logic [31:0] snap [NUM_SLOTS];
   int tests = 0;
   int fails = 0;

   card_slot_prefetcher #(
      .NUM_SLOTS(NUM_SLOTS), .BASE_ADDR(BASE_ADDR), .RD_LAT(RD_LAT),
      .NUM_IMAGES(NUM_IMAGES), .BLANK_IDX(BLANK_IDX), .STALL_LIMIT(STALL_LIMIT)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .cpu_req(cpu_req),
      .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .slot_sel(slot_sel), .slot_index(slot_index), .table_valid(table_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Single-cycle registered read port.
   always @(posedge clk) mem_rdata <= ram[mem_addr[5:0]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] filt(input logic [31:0] v);
      return (v < 32'(NUM_IMAGES)) ? v : 32'(BLANK_IDX);
   endfunction

   task automatic take_snapshot();
      for (int k = 0; k < NUM_SLOTS; k++) snap[k] = filt(ram[6'(BASE_ADDR + k)]);
   endtask

   // Runs one frame fetch from frame_start to the return to idle, predicting grant, address and
   // frame-stable slot output every cycle. mode: 0 no cpu traffic, 1 cpu_req held, 2 random cpu_req.
   task automatic run_fetch(input int mode, input int poke_cyc, input int poke_addr,
                            input logic [31:0] poke_val, input int watch_in, output int ncyc);
      int issued = 0;
      int consec = 0;
      int last = -1;
      int exp_n;
      logic [3:0] watch;
      logic exp_gnt;
      logic [31:0] exp_addr;
      watch = (watch_in < 0) ? 4'($urandom_range(0, NUM_SLOTS - 1)) : 4'(watch_in);
      slot_sel = watch;
      cpu_req = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      ncyc = 0;
      while (busy && ncyc < 400) begin
         if (ncyc == poke_cyc) ram[6'(poke_addr)] = poke_val;
         cpu_req  = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 99) < 60) : 1'b0;
         cpu_addr = 32'($urandom_range(0, 63));
         #1;
         exp_gnt  = cpu_req && (issued == NUM_SLOTS || consec < STALL_LIMIT);
         exp_addr = (issued < NUM_SLOTS && !exp_gnt) ? 32'(BASE_ADDR + issued) : cpu_addr;
         tests++;
         if (cpu_gnt !== exp_gnt) begin
            fails++;
            $display("FAIL cpu_gnt cycle %0d: got %b expected %b", ncyc, cpu_gnt, exp_gnt);
         end
         tests++;
         if (mem_addr !== exp_addr) begin
            fails++;
            $display("FAIL mem_addr cycle %0d: got %0d expected %0d", ncyc, mem_addr, exp_addr);
         end
         tests++;
         if (slot_index !== model_tbl[watch]) begin
            fails++;
            $display("FAIL frame_stable slot %0d cycle %0d: got %0d expected %0d",
                     watch, ncyc, slot_index, model_tbl[watch]);
         end
         if (issued < NUM_SLOTS) begin
            if (exp_gnt) consec++;
            else begin
               issued++;
               consec = 0;
               if (issued == NUM_SLOTS) last = ncyc;
            end
         end
         tick();
         ncyc++;
      end
      cpu_req = 1'b0;
      exp_n = (last < 0) ? -1 : last + 2 + RD_LAT;
      tests++;
      if (ncyc !== exp_n) begin
         fails++;
         $display("FAIL commit_latency: got %0d cycles expected %0d", ncyc, exp_n);
      end
   endtask

   task automatic test_reset();
      cpu_req = 1'b0;
      cpu_addr = 32'd5;
      #3;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (table_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", table_valid); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      tests++; if (cpu_gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt: got %b expected 0", cpu_gnt); end
      tests++; if (mem_addr !== 32'd5) begin fails++; $display("FAIL reset_addr: got %0d expected 5", mem_addr); end
      for (int s = 0; s < 16; s++) begin
         slot_sel = 4'(s);
         #1;
         tests++;
         if (slot_index !== 32'd0) begin fails++; $display("FAIL reset_slot%0d: got %0d expected 0", s, slot_index); end
      end
      cpu_req = 1'b1;
      #1;
      tests++; if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL idle_gnt: got %b expected 1", cpu_gnt); end
      cpu_req = 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = '0;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'(k);
      take_snapshot();
      run_fetch(0, -1, 0, '0, -1, n);
      tests++; if (n !== 12) begin fails++; $display("FAIL t1_latency: got %0d expected 12", n); end
      tests++; if (table_valid !== 1'b1) begin fails++; $display("FAIL t1_valid: got %b expected 1", table_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy: got %b expected 0", busy); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #1;
         tests++;
         if (slot_index !== 32'(k)) begin fails++; $display("FAIL t1_slot%0d: got %0d expected %0d", k, slot_index, k); end
         model_tbl[k] = snap[k];
      end
      for (int s = NUM_SLOTS; s < 16; s++) begin
         slot_sel = 4'(s);
         #1;
         tests++;
         if (slot_index !== 32'd0) begin fails++; $display("FAIL t1_oob%0d: got %0d expected 0", s, slot_index); end
      end
   endtask

   task automatic test_blank();
      int n;
      ram[18] = 32'd20;
      ram[19] = 32'd13;
      take_snapshot();
      run_fetch(0, -1, 0, '0, 2, n);
      slot_sel = 4'd2;
      #1;
      tests++; if (slot_index !== 32'(BLANK_IDX)) begin fails++; $display("FAIL t2_slot2: got %0d expected %0d", slot_index, BLANK_IDX); end
      slot_sel = 4'd3;
      #1;
      tests++; if (slot_index !== 32'd13) begin fails++; $display("FAIL t2_slot3: got %0d expected 13", slot_index); end
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = snap[k];
   endtask

   task automatic test_stall();
      int n;
      for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'(13 - k);
      take_snapshot();
      run_fetch(1, -1, 0, '0, -1, n);
      tests++; if (n !== 52) begin fails++; $display("FAIL t3_latency: got %0d expected 52", n); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #1;
         tests++;
         if (slot_index !== snap[k]) begin fails++; $display("FAIL t3_slot%0d: got %0d expected %0d", k, slot_index, snap[k]); end
         model_tbl[k] = snap[k];
      end
   endtask

   task automatic test_mid_fetch_write();
      int n;
      ram[20] = 32'd7;
      take_snapshot();
      run_fetch(0, -1, 0, '0, 4, n);
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = snap[k];
      take_snapshot();
      run_fetch(0, 5, 20, 32'd3, 4, n);
      slot_sel = 4'd4;
      #1;
      tests++; if (slot_index !== 32'd7) begin fails++; $display("FAIL t5_old: got %0d expected 7", slot_index); end
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = snap[k];
      take_snapshot();
      run_fetch(0, -1, 0, '0, 4, n);
      slot_sel = 4'd4;
      #1;
      tests++; if (slot_index !== 32'd3) begin fails++; $display("FAIL t5_new: got %0d expected 3", slot_index); end
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = snap[k];
   endtask

   task automatic test_overrun();
      int commits = 0;
      logic prev_busy;
      take_snapshot();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      ram[BASE_ADDR] = 32'd11;
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL t4_overrun_set: got %b expected 1", overrun); end
      prev_busy = busy;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (prev_busy && !busy) commits++;
         prev_busy = busy;
      end
      tests++; if (commits !== 1) begin fails++; $display("FAIL t4_commits: got %0d expected 1", commits); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t4_busy: got %b expected 0", busy); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #1;
         tests++;
         if (slot_index !== snap[k]) begin fails++; $display("FAIL t4_slot%0d: got %0d expected %0d", k, slot_index, snap[k]); end
         model_tbl[k] = snap[k];
      end
   endtask

   task automatic test_commit_collision();
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int k = 0; k < NUM_SLOTS; k++) model_tbl[k] = '0;
      for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'($urandom_range(0, 13));
      take_snapshot();
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (NUM_SLOTS + RD_LAT) tick();
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL tc_overrun_pre: got %b expected 0", overrun); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tc_busy_pre: got %b expected 1", busy); end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tc_busy_post: got %b expected 0", busy); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL tc_overrun: got %b expected 1", overrun); end
      tests++; if (table_valid !== 1'b1) begin fails++; $display("FAIL tc_valid: got %b expected 1", table_valid); end
      repeat (3) tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tc_no_refetch: got %b expected 0", busy); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #1;
         tests++;
         if (slot_index !== snap[k]) begin fails++; $display("FAIL tc_slot%0d: got %0d expected %0d", k, slot_index, snap[k]); end
         model_tbl[k] = snap[k];
      end
   endtask

   task automatic test_mid_reset();
      int n;
      for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'($urandom_range(0, 31));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t6_busy: got %b expected 0", busy); end
      tests++; if (table_valid !== 1'b0) begin fails++; $display("FAIL t6_valid: got %b expected 0", table_valid); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL t6_overrun: got %b expected 0", overrun); end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #0.1;
         tests++;
         if (slot_index !== 32'd0) begin fails++; $display("FAIL t6_slot%0d: got %0d expected 0", k, slot_index); end
         model_tbl[k] = '0;
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'($urandom_range(0, 31));
      take_snapshot();
      run_fetch(0, -1, 0, '0, -1, n);
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slot_sel = 4'(k);
         #1;
         tests++;
         if (slot_index !== snap[k]) begin fails++; $display("FAIL t6_slot_refetch%0d: got %0d expected %0d", k, slot_index, snap[k]); end
         model_tbl[k] = snap[k];
      end
   endtask

   task automatic test_random_traffic();
      int n;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < NUM_SLOTS; k++) ram[6'(BASE_ADDR + k)] = 32'($urandom_range(0, 31));
         take_snapshot();
         run_fetch(2, -1, 0, '0, -1, n);
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_sel = 4'(k);
            #1;
            tests++;
            if (slot_index !== snap[k]) begin
               fails++;
               $display("FAIL rand_f%0d_slot%0d: got %0d expected %0d", f, k, slot_index, snap[k]);
            end
            model_tbl[k] = snap[k];
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 64; a++) ram[a] = 32'(a);
      test_reset();
      test_basic();
      test_blank();
      test_stall();
      test_mid_fetch_write();
      test_overrun();
      test_commit_collision();
      test_mid_reset();
      test_random_traffic();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
